// File: rtl/sonic_upstream_gearbox_ctrl.sv
`default_nettype none
// ============================================================================
// sonic_upstream_gearbox_ctrl : sequences and checks a 40->64 gearbox, forwards words to a FIFO
// Optional macro SONIC_GB_AUTO_RESYNC_EN: automatic resync after 16 ERROR cycles.  Rev 1.0
// ============================================================================
module sonic_upstream_gearbox_ctrl #(
   parameter int OUTPUT_WIDTH   = 64,
   parameter int DROP_CNT_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ctrl_enable,
   input  logic                      ctrl_start,
   input  logic [OUTPUT_WIDTH-1:0]   gb_data_out,
   input  logic                      gb_data_valid,
   input  logic                      fifo_almost_full,
   output logic                      gb_reset,
   output logic [2:0]                phase,
   output logic                      fifo_wr_en,
   output logic [OUTPUT_WIDTH-1:0]   fifo_wr_data,
   output logic [31:0]               word_count,
   output logic [DROP_CNT_WIDTH-1:0] drop_count,
   output logic                      misalign,
   output logic                      busy
);

   localparam logic [2:0] c_st_idle     = 3'd0;
   localparam logic [2:0] c_st_reset_gb = 3'd1;
   localparam logic [2:0] c_st_align    = 3'd2;
   localparam logic [2:0] c_st_run      = 3'd3;
   localparam logic [2:0] c_st_error    = 3'd4;

   logic [2:0] r_state;
   logic [2:0] w_next_state;
   logic [3:0] r_cnt;
   logic       w_set_mis;
   logic       w_clear_mis;
   logic       w_cur_active;
   logic       w_next_active;
   logic       w_exp_valid;
   logic       w_accept;
   logic       w_write;
   logic       w_drop;
   logic [2:0] w_next_phase;
   logic       w_next_mis;

   assign w_cur_active  = (r_state == c_st_align) || (r_state == c_st_run) || (r_state == c_st_error);
   assign w_next_active = (w_next_state == c_st_align) || (w_next_state == c_st_run) ||
                          (w_next_state == c_st_error);

   // r_cnt restarts on every state change; it times RESET_GB and ERROR dwell
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= c_st_idle;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= (w_next_state != r_state) ? 4'd0 : r_cnt + 4'd1;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_set_mis    = 1'b0;
      w_clear_mis  = 1'b0;
      if (!ctrl_enable) begin
         w_next_state = c_st_idle;
      end else if (ctrl_start && w_cur_active) begin
         w_next_state = c_st_reset_gb;
         w_clear_mis  = 1'b1;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (ctrl_start) w_next_state = c_st_reset_gb;
            end
            c_st_reset_gb: begin
               if (r_cnt == 4'd1) w_next_state = c_st_align;
            end
            c_st_align: begin
               if (gb_data_valid) begin
                  w_next_state = c_st_error;
                  w_set_mis    = 1'b1;
               end else if (phase == 3'd2) begin
                  w_next_state = c_st_run;
               end
            end
            c_st_run: begin
               if (gb_data_valid != w_exp_valid) begin
                  w_next_state = c_st_error;
                  w_set_mis    = 1'b1;
               end
            end
            c_st_error: begin
`ifdef SONIC_GB_AUTO_RESYNC_EN
               if (r_cnt == 4'd15) begin
                  w_next_state = c_st_reset_gb;
                  w_clear_mis  = 1'b1;
               end
`else
               w_next_state = c_st_error;
`endif
            end
            default: w_next_state = c_st_idle;
         endcase
      end
   end

   always_comb begin
      w_exp_valid = 1'b0;
      case (phase)
         3'd0, 3'd1, 3'd3, 3'd5, 3'd6: w_exp_valid = 1'b1;
         default:                      w_exp_valid = 1'b0;
      endcase
      w_accept     = (r_state == c_st_run) && gb_data_valid && w_exp_valid;
      w_write      = w_accept && !fifo_almost_full;
      w_drop       = w_accept && fifo_almost_full;
      w_next_phase = 3'd0;
      if (w_next_active && w_cur_active) w_next_phase = phase + 3'd1;
      w_next_mis   = misalign;
      if (w_clear_mis)    w_next_mis = 1'b0;
      else if (w_set_mis) w_next_mis = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gb_reset     <= 1'b1;
         phase        <= 3'd0;
         fifo_wr_en   <= 1'b0;
         fifo_wr_data <= '0;
         word_count   <= 32'd0;
         drop_count   <= '0;
         misalign     <= 1'b0;
         busy         <= 1'b0;
      end else begin
         gb_reset   <= (w_next_state == c_st_idle) || (w_next_state == c_st_reset_gb);
         busy       <= (w_next_state != c_st_idle);
         phase      <= w_next_phase;
         misalign   <= w_next_mis;
         fifo_wr_en <= w_write;
         if (w_write) begin
            fifo_wr_data <= gb_data_out;
            word_count   <= word_count + 32'd1;
         end
         if (w_drop && (drop_count != {DROP_CNT_WIDTH{1'b1}})) begin
            drop_count <= drop_count + DROP_CNT_WIDTH'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sonic_upstream_gearbox_ctrl.sv
`default_nettype none
// ============================================================================
// tb_sonic_upstream_gearbox_ctrl : randomized bench against a mode/timer reference model
// Honours SONIC_GB_AUTO_RESYNC_EN.  Rev 1.0
// ============================================================================
module tb_sonic_upstream_gearbox_ctrl;

   localparam int OW = 64;
   localparam int DW = 8;
   localparam int M_IDLE = 0, M_RGB = 1, M_ALIGN = 2, M_RUN = 3, M_ERR = 4;
   localparam logic [7:0] VALID_MASK = 8'b0110_1011;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          ctrl_enable = 1'b0;
   logic          ctrl_start = 1'b0;
   logic [OW-1:0] gb_data_out = '0;
   logic          gb_data_valid = 1'b0;
   logic          fifo_almost_full = 1'b0;
   logic          gb_reset;
   logic [2:0]    phase;
   logic          fifo_wr_en;
   logic [OW-1:0] fifo_wr_data;
   logic [31:0]   word_count;
   logic [DW-1:0] drop_count;
   logic          misalign;
   logic          busy;

   sonic_upstream_gearbox_ctrl #(.OUTPUT_WIDTH(OW), .DROP_CNT_WIDTH(DW)) dut (
      .clk(clk), .reset(reset), .ctrl_enable(ctrl_enable), .ctrl_start(ctrl_start),
      .gb_data_out(gb_data_out), .gb_data_valid(gb_data_valid),
      .fifo_almost_full(fifo_almost_full), .gb_reset(gb_reset), .phase(phase),
      .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .word_count(word_count),
      .drop_count(drop_count), .misalign(misalign), .busy(busy)
   );

   always #5 clk = ~clk;

   // reference model: operating mode, cycles spent in that mode, and derived outputs
   int            m_mode, m_tim, m_phase;
   bit            m_wr, m_mis;
   logic [OW-1:0] m_wdata;
   logic [31:0]   m_wc;
   int            m_dc;
   int            k_word;
   int            total = 0, bad = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   function automatic bit is_active(input int m);
      return (m == M_ALIGN) || (m == M_RUN) || (m == M_ERR);
   endfunction

   // 64-bit words cut LSB-first from a stream of consecutive 40-bit counter values
   function automatic logic [63:0] pack_word(input int k);
      logic [63:0] w;
      longint b, v;
      for (int i = 0; i < 64; i++) begin
         b    = 64 * longint'(k) + longint'(i);
         v    = b / 40;
         w[i] = v[b % 40];
      end
      return w;
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE; m_tim = 0; m_phase = 0; m_wr = 0; m_mis = 0;
      m_wdata = '0; m_wc = 32'd0; m_dc = 0;
   endtask

   task automatic model_edge();
      int nm;
      bit exp_v;
      nm    = m_mode;
      exp_v = VALID_MASK[m_phase];
      m_wr  = 0;
      if (m_mode == M_RUN && gb_data_valid && exp_v) begin
         if (!fifo_almost_full) begin
            m_wr = 1; m_wdata = gb_data_out; m_wc = m_wc + 32'd1;
         end else if (m_dc < (1 << DW) - 1) begin
            m_dc++;
         end
      end
      if (!ctrl_enable) nm = M_IDLE;
      else if (ctrl_start && is_active(m_mode)) begin nm = M_RGB; m_mis = 0; end
      else if (m_mode == M_IDLE && ctrl_start) nm = M_RGB;
      else if (m_mode == M_RGB && m_tim == 1) nm = M_ALIGN;
      else if (m_mode == M_ALIGN && gb_data_valid) begin nm = M_ERR; m_mis = 1; end
      else if (m_mode == M_ALIGN && m_phase == 2) nm = M_RUN;
      else if (m_mode == M_RUN && gb_data_valid != exp_v) begin nm = M_ERR; m_mis = 1; end
`ifdef SONIC_GB_AUTO_RESYNC_EN
      else if (m_mode == M_ERR && m_tim == 15) begin nm = M_RGB; m_mis = 0; end
`endif
      if (is_active(nm)) m_phase = is_active(m_mode) ? (m_phase + 1) % 8 : 0;
      else m_phase = 0;
      m_tim  = (nm == m_mode) ? m_tim + 1 : 0;
      m_mode = nm;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".gb_reset"}, 64'(gb_reset), 64'(m_mode == M_IDLE || m_mode == M_RGB));
      check({tag, ".busy"}, 64'(busy), 64'(m_mode != M_IDLE));
      check({tag, ".phase"}, 64'(phase), 64'(m_phase));
      check({tag, ".wr_en"}, 64'(fifo_wr_en), 64'(m_wr));
      check({tag, ".wr_data"}, fifo_wr_data, m_wdata);
      check({tag, ".word_count"}, 64'(word_count), 64'(m_wc));
      check({tag, ".drop_count"}, 64'(drop_count), 64'(m_dc));
      check({tag, ".misalign"}, 64'(misalign), 64'(m_mis));
   endtask

   task automatic drive_gb(input bit fault);
      gb_data_out = {$urandom, $urandom};
      if (m_mode == M_RUN) begin
         gb_data_valid = VALID_MASK[m_phase] ^ fault;
         if (gb_data_valid) begin
            gb_data_out = pack_word(k_word);
            k_word++;
         end
      end else if (m_mode == M_ALIGN) begin
         gb_data_valid = fault;
      end else begin
         gb_data_valid = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic step(input string tag, input bit fault);
      drive_gb(fault);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
      ctrl_start = 1'b0;
   endtask

   task automatic start_to_run();
      ctrl_start = 1'b1;
      step("start", 0);
      repeat (5) step("bringup", 0);
   endtask

   int wcnt, pulses;
   logic [31:0] wc0;
   logic [DW-1:0] dc0;

   initial begin
      k_word = 0;
      model_reset();
      #1 reset = 1'b1;
      #1 check_all("reset");
      @(posedge clk);
      #1 reset = 1'b0;
      ctrl_enable = 1'b1;
      repeat (4) step("idle", 0);

      start_to_run();
      wcnt = 0;
      repeat (80) begin
         step("nominal", 0);
         if (fifo_wr_en) wcnt++;
      end
      check("nom_writes", 64'(wcnt), 64'd50);
      check("nom_word_count", 64'(word_count), 64'd50);
      check("nom_misalign", 64'(misalign), 64'd0);

      fifo_almost_full = 1'b1;
      dc0 = drop_count;
      wcnt = 0;
      repeat (16) begin
         step("backpressure", 0);
         if (fifo_wr_en) wcnt++;
      end
      check("bp_drops", 64'(drop_count - dc0), 64'd10);
      check("bp_no_write", 64'(wcnt), 64'd0);
      repeat (420) step("saturate", 0);
      check("drop_saturated", 64'(drop_count), 64'hFF);
      fifo_almost_full = 1'b0;

      for (int i = 0; i < 8 && m_phase != 2; i++) step("seek_phase2", 0);
      step("misalign_inject", 1);
      check("mis_flag", 64'(misalign), 64'd1);
      check("mis_no_write", 64'(fifo_wr_en), 64'd0);
      check("mis_in_error", 64'({busy, gb_reset}), 64'b10);
      wc0 = word_count;
      pulses = 0;
      repeat (100) begin
         step("error_dwell", 0);
         if (gb_reset) pulses++;
      end
`ifdef SONIC_GB_AUTO_RESYNC_EN
      check("resync_pulse", 64'(pulses), 64'd2);
      check("resync_mis_clear", 64'(misalign), 64'd0);
      check("resync_run_resumed", 64'(word_count > wc0), 64'd1);
`else
      check("err_no_gb_reset", 64'(pulses), 64'd0);
      check("err_mis_held", 64'(misalign), 64'd1);
      check("err_wc_held", 64'(word_count), 64'(wc0));
`endif

      start_to_run();
      repeat (3) step("run", 0);
      ctrl_enable = 1'b0;
      ctrl_start = 1'b1;
      step("disable_start", 0);
      check("disable_gb_reset", 64'(gb_reset), 64'd1);
      check("disable_idle", 64'(busy), 64'd0);
      ctrl_enable = 1'b1;
      start_to_run();
      repeat (10) step("run2", 0);
      #2 reset = 1'b1;
      #1 model_reset();
      check_all("async_reset");
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (5) step("post_reset_idle", 0);

      for (int i = 0; i < 800; i++) begin
         ctrl_enable      = ($urandom % 50) != 0;
         ctrl_start       = ($urandom % 40) == 0;
         fifo_almost_full = ($urandom % 4) == 0;
         step("random", ($urandom % 60) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
